// File: rtl/synthesizer_soc_keycode_fifo_if.sv
// Avalon-MM register bus plus keycode event stream for the keycode FIFO.
// The slave modport is the FIFO side; the master modport is the CPU/voice side.
interface synthesizer_soc_keycode_fifo_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_port;
  logic [DATA_W-1:0] ev_data;
  logic              ev_valid;
  logic              ev_ready;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata, ev_ready,
    input  readdata, out_port, ev_data, ev_valid, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata, ev_ready,
    output readdata, out_port, ev_data, ev_valid, irq
  );
endinterface

// File: rtl/synthesizer_soc_keycode_fifo.sv
// Keycode event FIFO behind an Avalon-MM slave, drained over a valid/ready stream.
// Optional macro KEYCODE_FIFO_IRQ_EN adds the IRQ_EN register at addr2 and a live irq.
module synthesizer_soc_keycode_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input logic                           clk,
  input logic                           reset,
  synthesizer_soc_keycode_fifo_if.slave bus
);
  localparam int                    DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   ZERO_COUNT = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0]   ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic                  overflow_r;
  logic [DATA_W-1:0]     out_port_r;
  logic [31:0]           readdata_s;
  logic                  wr_s;
  logic                  push_req_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;
  logic                  flush_s;
  logic                  ovf_clr_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  unused_s;

  assign wr_s       = bus.chipselect & ~bus.write_n;
  assign push_req_s = wr_s & (bus.address == 2'd0);
  assign flush_s    = wr_s & (bus.address == 2'd1) & bus.writedata[1];
  assign ovf_clr_s  = wr_s & (bus.address == 2'd1) & bus.writedata[0];
  assign empty_s    = (count_r == ZERO_COUNT);
  assign full_s     = (count_r == FULL_COUNT);
  assign pop_s      = ~empty_s & bus.ev_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign drop_s     = push_req_s & full_s & ~pop_s;
  assign unused_s   = ^bus.writedata;

  // Next occupancy: flush dominates, simultaneous push/pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (flush_s) begin
      count_nxt_s = ZERO_COUNT;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + ONE_COUNT;
        2'b01:   count_nxt_s = count_r - ONE_COUNT;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Queue storage; contents are don't-care until pushed, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.writedata[DATA_W-1:0];
    end
  end

  // Pointers, occupancy, sticky overflow and the legacy mirror register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= ZERO_COUNT;
      overflow_r <= 1'b0;
      out_port_r <= '0;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      if (push_req_s) out_port_r <= bus.writedata[DATA_W-1:0];
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

`ifdef KEYCODE_FIFO_IRQ_EN
  logic ien_r;
  logic irq_r;

  // Interrupt enable register and registered interrupt from current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      ien_r <= 1'b0;
      irq_r <= 1'b0;
    end else begin
      if (wr_s && (bus.address == 2'd2)) ien_r <= bus.writedata[0];
      irq_r <= overflow_r | (~empty_s & ien_r);
    end
  end

  assign bus.irq = irq_r;
`else
  assign bus.irq = 1'b0;
`endif

  // Side-effect-free register read mux.
  always_comb begin
    readdata_s = 32'd0;
    case (bus.address)
      2'd0: readdata_s[DATA_W-1:0] = out_port_r;
      2'd1: begin
        readdata_s[0]                = empty_s;
        readdata_s[1]                = full_s;
        readdata_s[2]                = overflow_r;
        readdata_s[8+DEPTH_LOG2:8]   = count_r;
      end
`ifdef KEYCODE_FIFO_IRQ_EN
      2'd2: readdata_s[0] = ien_r;
`endif
      default: readdata_s = 32'd0;
    endcase
  end

  assign bus.readdata = readdata_s;
  assign bus.out_port = out_port_r;
  assign bus.ev_data  = mem_r[rd_ptr_r];
  assign bus.ev_valid = ~empty_s;
endmodule

// File: tb/tb_synthesizer_soc_keycode_fifo.sv
// Directed plus randomized bench for the keycode FIFO against a queue-based model.
// Build with KEYCODE_FIFO_IRQ_EN defined to exercise the interrupt path.
module tb_synthesizer_soc_keycode_fifo;
  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  synthesizer_soc_keycode_fifo_if #(.DATA_W(DATA_W)) bus ();

  synthesizer_soc_keycode_fifo #(
    .DATA_W(DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] q_m[$];
  logic       ovf_m;
  logic [7:0] out_m;
  logic       ien_m;
  logic       irq_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then let the DUT clock.
  task automatic step(input logic rst, input logic cs, input logic wn, input logic [1:0] a,
                      input logic [31:0] wd, input logic rdy);
    logic wr;
    logic pop;
    reset          = rst;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    bus.ev_ready   = rdy;
    wr  = cs & ~wn;
    pop = (q_m.size() != 0) && rdy;
    if (rst) begin
      q_m.delete();
      ovf_m = 1'b0;
      out_m = 8'h00;
      ien_m = 1'b0;
      irq_m = 1'b0;
    end else begin
`ifdef KEYCODE_FIFO_IRQ_EN
      irq_m = ovf_m | ((q_m.size() != 0) && ien_m);
`else
      irq_m = 1'b0;
`endif
      if (pop) void'(q_m.pop_front());
      if (wr && a == 2'd0) begin
        out_m = wd[7:0];
        if (q_m.size() < DEPTH) q_m.push_back(wd[7:0]);
        else ovf_m = 1'b1;
      end
      if (wr && a == 2'd1) begin
        if (wd[0]) ovf_m = 1'b0;
        if (wd[1]) q_m.delete();
      end
`ifdef KEYCODE_FIFO_IRQ_EN
      if (wr && a == 2'd2) ien_m = wd[0];
`endif
    end
    @(posedge clk);
    #1;
    reset          = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
    bus.ev_ready   = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] st;
    st        = 32'd0;
    st[0]     = (q_m.size() == 0);
    st[1]     = (q_m.size() == DEPTH);
    st[2]     = ovf_m;
    st[12:8]  = 5'(q_m.size());
    check({tag, " ev_valid"}, {31'd0, bus.ev_valid}, {31'd0, q_m.size() != 0});
    if (q_m.size() != 0) check({tag, " ev_data"}, {24'd0, bus.ev_data}, {24'd0, q_m[0]});
    check({tag, " out_port"}, {24'd0, bus.out_port}, {24'd0, out_m});
    check({tag, " irq"}, {31'd0, bus.irq}, {31'd0, irq_m});
    bus.address = 2'd0;
    #1 check({tag, " rd_data"}, bus.readdata, {24'd0, out_m});
    bus.address = 2'd1;
    #1 check({tag, " rd_status"}, bus.readdata, st);
    bus.address = 2'd2;
`ifdef KEYCODE_FIFO_IRQ_EN
    #1 check({tag, " rd_addr2"}, bus.readdata, {31'd0, ien_m});
`else
    #1 check({tag, " rd_addr2"}, bus.readdata, 32'd0);
`endif
    bus.address = 2'd3;
    #1 check({tag, " rd_addr3"}, bus.readdata, 32'd0);
    bus.address = 2'd0;
  endtask

  initial begin
    logic [1:0]  ra;
    logic [31:0] rwd;
    reset          = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
    bus.ev_ready   = 1'b0;
    ovf_m = 1'b0; out_m = 8'h00; ien_m = 1'b0; irq_m = 1'b0;

    step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    check_state("reset");

    // Single push then drain
    step(1'b0, 1'b1, 1'b0, 2'd0, 32'h3C, 1'b0);
    check_state("first_push");
    step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    check_state("first_drain");

    // Back-to-back pushes preserved in order
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 32'h10 + i, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_state("order_pop");
      step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    end
    check_state("order_empty");
    step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    check_state("empty_ready_ignored");

    // Fill, overflow, clear
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 2'd0, $urandom, 1'b0);
    check_state("full");
    step(1'b0, 1'b1, 1'b0, 2'd0, 32'h7F, 1'b0);
    check_state("overflow");
    step(1'b0, 1'b1, 1'b0, 2'd1, 32'h1, 1'b0);
    check_state("ovf_clear");

    // Push while full with a simultaneous pop
    step(1'b0, 1'b1, 1'b0, 2'd0, 32'h55, 1'b1);
    check_state("full_push_pop");
    for (int i = 0; i < DEPTH; i++) begin
      check_state("full_drain");
      step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    end
    check_state("full_drained");

    // Flush with concurrent pop
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 32'hA0 + i, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd1, 32'h2, 1'b1);
    check_state("flush");

    // Interrupt enable path (addr2 inert without the macro)
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 32'h20, 1'b0);
    check_state("irq_push");
    step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
    check_state("irq_on");
    step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    check_state("irq_pop");
    step(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
    check_state("irq_off");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ra  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rwd = $urandom;
      if (ra == 2'd1) rwd = {30'd0, ($urandom_range(0, 7) == 0), rwd[0]};
      step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), ra, rwd,
           ($urandom_range(0, 2) == 0));
      check_state("random");
    end

    // Reset in the middle of traffic
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 2'd0, $urandom, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 32'h99, 1'b1);
    check_state("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
